hp_multi_ch_drv: RTL

Parametrised multi-channel successor to the HP synthesiser driver. It accepts N_CH independent 32-bit frequency requests and converts each to an FTW_W-bit tuning word by fixed-point multiply. Each tuning word is expanded into a burst of 24-bit SPI register writes followed by an IO-update write. A built-in mode-0 SPI master serialises the words. Pending channel requests are arbitrated round-robin and coalesced.

---
 rtl/hp_multi_ch_drv_if.sv | 23 ++
 rtl/hp_multi_ch_drv.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hp_multi_ch_drv_if.sv
// Request/status and SPI pin bundle shared by hp_multi_ch_drv and its host.
interface hp_multi_ch_drv_if #(
    parameter int N_CH = 2
);
    logic [32*N_CH-1:0] freq_in;
    logic [N_CH-1:0]    freq_vld;
    logic               busy;
    logic [N_CH-1:0]    ch_done;
    logic [N_CH-1:0]    req_drop;
    logic               sclk_spi;
    logic               cs_spi;
    logic               sdo_spi;

    modport master (
        output freq_in, freq_vld,
        input  busy, ch_done, req_drop, sclk_spi, cs_spi, sdo_spi
    );

    modport slave (
        input  freq_in, freq_vld,
        output busy, ch_done, req_drop, sclk_spi, cs_spi, sdo_spi
    );
endinterface

// File: rtl/hp_multi_ch_drv.sv
// Multi-channel synthesiser driver: round-robin request arbitration, frequency-to-FTW
// multiply, and a mode-0 SPI master emitting one register-write burst per request.
module hp_multi_ch_drv #(
    parameter int          N_CH        = 2,
    parameter int          FTW_W       = 48,
    parameter logic [31:0] FTW_MULT    = 32'd1,
    parameter int          MULT_SHIFT  = 0,
    parameter logic [15:0] BASE_ADDR   = 16'h0100,
    parameter logic [15:0] ADDR_STRIDE = 16'h0010,
    parameter logic [15:0] UPD_ADDR    = 16'h000F,
    parameter int          CLK_DIV     = 4,
    parameter int          CS_GAP      = 4
) (
    input  logic             sys_clk,
    input  logic             rst,
    hp_multi_ch_drv_if.slave bus
);
    localparam int NBYTES = FTW_W / 8;
    localparam int CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int WI_W   = $clog2(NBYTES + 1);
    localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int GAP_W  = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_ARB, S_CALC1, S_CALC2, S_LOAD, S_SHIFT, S_GAP, S_DONE
    } state_e;

    state_e            state_q, state_d;
    logic [N_CH-1:0]   pend_q, pend_d, take_s, drop_s;
    logic [31:0]       pend_freq_q [N_CH];
    logic [31:0]       pend_freq_d [N_CH];
    logic [CH_W-1:0]   ptr_q, ptr_d, chan_q, chan_d, pick_s;
    logic [31:0]       freq_q, freq_d;
    logic [63:0]       prod_q, prod_d;
    logic [FTW_W-1:0]  ftw_q, ftw_d;
    logic [WI_W-1:0]   word_idx_q, word_idx_d;
    logic [4:0]        bit_q, bit_d;
    logic              phase_q, phase_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [GAP_W-1:0]  gap_q, gap_d;
    logic [23:0]       word_s;
    logic              busy_q, busy_d, cs_q, cs_d, sclk_q, sclk_d, sdo_q, sdo_d;
    logic [N_CH-1:0]   done_q, done_d, drop_q;

    // Words 0..NBYTES-1 carry FTW bytes MSB-first; the last word strobes IO-update.
    function automatic logic [23:0] build_word(input logic [WI_W-1:0] idx,
                                               input logic [CH_W-1:0] ch,
                                               input logic [FTW_W-1:0] ftw);
        logic [15:0] addr;
        logic [7:0]  byte_v;
        addr   = BASE_ADDR + 16'(ch) * ADDR_STRIDE + 16'(idx);
        byte_v = 8'(ftw >> (8 * (NBYTES - 1 - int'(idx))));
        if (idx == WI_W'(NBYTES)) begin
            build_word = {UPD_ADDR, 8'h01};
        end else begin
            build_word = {addr, byte_v};
        end
    endfunction

    // Round-robin pick: first pending channel at or after the pointer.
    always_comb begin
        int   idx;
        logic found;
        idx    = 0;
        found  = 1'b0;
        pick_s = '0;
        for (int i = 0; i < N_CH; i++) begin
            idx = (int'(ptr_q) + i) % N_CH;
            if (!found && pend_q[idx]) begin
                found  = 1'b1;
                pick_s = CH_W'(idx);
            end else begin
                found  = found;
            end
        end
    end

    // Pending capture; a strobe coinciding with the arbiter's take becomes a fresh request.
    always_comb begin
        take_s = '0;
        if (state_q == S_ARB) begin
            take_s[pick_s] = 1'b1;
        end else begin
            take_s = '0;
        end
        for (int c = 0; c < N_CH; c++) begin
            pend_d[c]      = bus.freq_vld[c] | (pend_q[c] & ~take_s[c]);
            drop_s[c]      = bus.freq_vld[c] & pend_q[c] & ~take_s[c];
            pend_freq_d[c] = bus.freq_vld[c] ? bus.freq_in[32*c +: 32] : pend_freq_q[c];
        end
    end

    // Next-state and datapath sequencing.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        chan_d     = chan_q;
        freq_d     = freq_q;
        prod_d     = prod_q;
        ftw_d      = ftw_q;
        word_idx_d = word_idx_q;
        bit_d      = bit_q;
        phase_d    = phase_q;
        div_d      = div_q;
        gap_d      = gap_q;
        case (state_q)
            S_IDLE: begin
                if (|pend_q) state_d = S_ARB;
                else         state_d = S_IDLE;
            end
            S_ARB: begin
                chan_d  = pick_s;
                freq_d  = pend_freq_q[pick_s];
                ptr_d   = (int'(pick_s) == N_CH - 1) ? '0 : pick_s + CH_W'(1);
                state_d = S_CALC1;
            end
            S_CALC1: begin
                prod_d  = {32'd0, freq_q} * {32'd0, FTW_MULT};
                state_d = S_CALC2;
            end
            S_CALC2: begin
                ftw_d      = FTW_W'(prod_q >> MULT_SHIFT);
                word_idx_d = '0;
                state_d    = S_LOAD;
            end
            S_LOAD: begin
                bit_d   = 5'd23;
                phase_d = 1'b0;
                div_d   = '0;
                state_d = S_SHIFT;
            end
            S_SHIFT: begin
                if (div_q == DIV_W'(CLK_DIV - 1)) begin
                    div_d = '0;
                    if (!phase_q) begin
                        phase_d = 1'b1;
                    end else if (bit_q == 5'd0) begin
                        gap_d   = '0;
                        state_d = S_GAP;
                    end else begin
                        bit_d   = bit_q - 5'd1;
                        phase_d = 1'b0;
                    end
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            S_GAP: begin
                if (gap_q != GAP_W'(CS_GAP - 1)) begin
                    gap_d = gap_q + GAP_W'(1);
                end else if (word_idx_q == WI_W'(NBYTES)) begin
                    state_d = S_DONE;
                end else begin
                    word_idx_d = word_idx_q + WI_W'(1);
                    state_d    = S_LOAD;
                end
            end
            S_DONE: begin
                if (|pend_q) state_d = S_ARB;
                else         state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output decode from the next state so every pin leaves a flop.
    always_comb begin
        word_s = build_word(word_idx_d, chan_d, ftw_d);
        busy_d = (state_d != S_IDLE);
        cs_d   = 1'b1;
        sclk_d = 1'b0;
        sdo_d  = 1'b0;
        done_d = '0;
        case (state_d)
            S_LOAD: begin
                cs_d  = 1'b0;
                sdo_d = word_s[23];
            end
            S_SHIFT: begin
                cs_d   = 1'b0;
                sclk_d = phase_d;
                sdo_d  = word_s[bit_d];
            end
            S_DONE:  done_d[chan_d] = 1'b1;
            default: cs_d = 1'b1;
        endcase
    end

    // State register.
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Request and datapath registers.
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            pend_q     <= '0;
            ptr_q      <= '0;
            chan_q     <= '0;
            freq_q     <= '0;
            prod_q     <= '0;
            ftw_q      <= '0;
            word_idx_q <= '0;
            bit_q      <= '0;
            phase_q    <= 1'b0;
            div_q      <= '0;
            gap_q      <= '0;
            for (int c = 0; c < N_CH; c++) pend_freq_q[c] <= '0;
        end else begin
            pend_q     <= pend_d;
            ptr_q      <= ptr_d;
            chan_q     <= chan_d;
            freq_q     <= freq_d;
            prod_q     <= prod_d;
            ftw_q      <= ftw_d;
            word_idx_q <= word_idx_d;
            bit_q      <= bit_d;
            phase_q    <= phase_d;
            div_q      <= div_d;
            gap_q      <= gap_d;
            for (int c = 0; c < N_CH; c++) pend_freq_q[c] <= pend_freq_d[c];
        end
    end

    // Output registers; reset forces CS high and SCLK low at once.
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            busy_q <= 1'b0;
            cs_q   <= 1'b1;
            sclk_q <= 1'b0;
            sdo_q  <= 1'b0;
            done_q <= '0;
            drop_q <= '0;
        end else begin
            busy_q <= busy_d;
            cs_q   <= cs_d;
            sclk_q <= sclk_d;
            sdo_q  <= sdo_d;
            done_q <= done_d;
            drop_q <= drop_s;
        end
    end

    assign bus.busy     = busy_q;
    assign bus.cs_spi   = cs_q;
    assign bus.sclk_spi = sclk_q;
    assign bus.sdo_spi  = sdo_q;
    assign bus.ch_done  = done_q;
    assign bus.req_drop = drop_q;
endmodule
